// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
//   state_t      : resolution FSM encoding (NORMAL, REDIRECT, DRAIN)
//   ENT_*        : bit offsets of the fields inside a packed queue entry
//   OPC_*        : RV32 opcodes of the instructions tracked by the queue
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    localparam int XLEN = 32;

    // Entry layout, MSB to LSB: {taken, target, pc4, is_cond}
    localparam int ENT_COND_LSB  = 0;
    localparam int ENT_PC4_LSB   = 1;
    localparam int ENT_TGT_LSB   = 1 + XLEN;
    localparam int ENT_TAKEN_LSB = 1 + 2 * XLEN;
    localparam int ENTRY_W       = 2 + 2 * XLEN;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/branch_resolve_ctrl_pred_queue.sv
// In-order FIFO of outstanding predictions.
//   clk, reset      : clock, synchronous active-high reset
//   push, wdata     : write one entry (caller guarantees !full or same-cycle pop)
//   pop             : retire the head entry (caller guarantees !empty)
//   clear           : drop all entries, overrides push/pop
//   rdata           : head entry, combinational
//   full, empty     : occupancy flags decoded from the extended pointers
module pred_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only read while the pointers say valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (rd_ptr == wr_ptr);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: queues fetch-time predictions, checks the
// oldest one against the execute-stage outcome, and drives predictor update,
// redirect and flush.
//   clk, reset                          : clock, synchronous active-high reset
//   push_*                              : prediction issued at fetch
//   resolve_*                           : actual outcome of the oldest branch/jump
//   full, empty                         : queue occupancy
//   state_update_en, eval_branch, flush : one-cycle pulses, cycle after resolve
//   redirect_pc                         : correct next PC while eval_branch=1
//   err_underflow, err_overflow         : sticky protocol errors
//   branch_cnt, mispredict_cnt          : saturating performance counters
//
// state    | meaning
// NORMAL   | accepting pushes and resolves
// REDIRECT | one cycle, redirect/flush pulses visible, inputs ignored
// DRAIN    | DRAIN_CYCLES cycles of pipeline refill, inputs ignored
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic             push_taken,
    input  logic [31:0]      push_target,
    input  logic [31:0]      push_pc4,
    input  logic             push_is_cond,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    output logic             full,
    output logic             empty,
    output logic             state_update_en,
    output logic             eval_branch,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             err_underflow,
    output logic             err_overflow,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t               state, state_nxt;
    logic [DW-1:0]        drain_cnt, drain_nxt;
    logic [ENTRY_W-1:0]   q_wdata, q_rdata;
    logic                 q_push, q_pop, q_clear;
    logic                 head_taken, head_cond;
    logic [XLEN-1:0]      head_target, head_pc4;
    logic                 normal, res_ok, mispredict, overflow, underflow;

    assign q_wdata     = {push_taken, push_target, push_pc4, push_is_cond};
    assign head_taken  = q_rdata[ENT_TAKEN_LSB];
    assign head_target = q_rdata[ENT_TGT_LSB +: XLEN];
    assign head_pc4    = q_rdata[ENT_PC4_LSB +: XLEN];
    assign head_cond   = q_rdata[ENT_COND_LSB];

    assign normal     = (state == ST_NORMAL);
    assign res_ok     = normal && resolve_valid && !empty;
    assign mispredict = res_ok && ((head_taken != resolve_taken) ||
                                   (head_taken && resolve_taken && (head_target != resolve_target)));
    assign underflow  = normal && resolve_valid && empty;

    // A mispredict clears the whole queue (everything behind the head is
    // wrong-path), so the head pop and any same-cycle push are subsumed.
    assign q_clear  = mispredict;
    assign q_pop    = res_ok && !mispredict;
    assign q_push   = normal && push_valid && !mispredict && (!full || q_pop);
    assign overflow = normal && push_valid && !mispredict && full && !q_pop;

    pred_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .clear (q_clear),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_NORMAL;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            ST_NORMAL: begin
                if (mispredict) state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (DRAIN_CYCLES == 0) begin
                    state_nxt = ST_NORMAL;
                end else begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) state_nxt = ST_NORMAL;
                else                 drain_nxt = drain_cnt - 1'b1;
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_update_en <= 1'b0;
            eval_branch     <= 1'b0;
            flush           <= 1'b0;
            redirect_pc     <= '0;
            err_underflow   <= 1'b0;
            err_overflow    <= 1'b0;
            branch_cnt      <= '0;
            mispredict_cnt  <= '0;
        end else begin
            state_update_en <= res_ok && head_cond;
            eval_branch     <= mispredict;
            flush           <= mispredict;
            if (mispredict) redirect_pc <= resolve_taken ? resolve_target : head_pc4;
            if (underflow)  err_underflow <= 1'b1;
            if (overflow)   err_overflow  <= 1'b1;
            if (res_ok && (branch_cnt != '1))         branch_cnt     <= branch_cnt + 1'b1;
            if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: stimulus pushes the expected
// pulse set for each resolve, a forked monitor compares whenever pulses appear.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        push_valid = 0, push_taken = 0, push_is_cond = 0;
    logic [31:0] push_target = 0, push_pc4 = 0;
    logic        resolve_valid = 0, resolve_taken = 0;
    logic [31:0] resolve_target = 0;
    logic        full, empty, state_update_en, eval_branch, flush;
    logic        err_underflow, err_overflow;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispredict_cnt;

    logic        push_valid_s = 0, resolve_valid_s = 0, resolve_taken_s = 0;
    logic        full_s, empty_s, sue_s, eval_s, flush_s, eu_s, eo_s;
    logic [31:0] redirect_pc_s;
    logic [3:0]  branch_cnt_s, mispredict_cnt_s;

    typedef struct {
        logic        sue;
        logic        eval;
        logic        fl;
        logic [31:0] rpc;
    } exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DEPTH(4), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_taken(push_taken), .push_target(push_target),
        .push_pc4(push_pc4), .push_is_cond(push_is_cond),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .full(full), .empty(empty), .state_update_en(state_update_en),
        .eval_branch(eval_branch), .redirect_pc(redirect_pc), .flush(flush),
        .err_underflow(err_underflow), .err_overflow(err_overflow),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_resolve_ctrl #(.DEPTH(4), .DRAIN_CYCLES(0), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .push_valid(push_valid_s), .push_taken(1'b1), .push_target(32'h10),
        .push_pc4(32'h4), .push_is_cond(1'b1),
        .resolve_valid(resolve_valid_s), .resolve_taken(resolve_taken_s),
        .resolve_target(32'h0),
        .full(full_s), .empty(empty_s), .state_update_en(sue_s),
        .eval_branch(eval_s), .redirect_pc(redirect_pc_s), .flush(flush_s),
        .err_underflow(eu_s), .err_overflow(eo_s),
        .branch_cnt(branch_cnt_s), .mispredict_cnt(mispredict_cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [31:0] ptg,
                         input logic [31:0] ppc4, input logic pc,
                         input logic rv, input logic rt, input logic [31:0] rtg);
        push_valid     = pv;
        push_taken     = pt;
        push_target    = ptg;
        push_pc4       = ppc4;
        push_is_cond   = pc;
        resolve_valid  = rv;
        resolve_taken  = rt;
        resolve_target = rtg;
        step();
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic expect_pulse(input logic sue, input logic ev, input logic fl, input logic [31:0] rpc);
        exp_q.push_back('{sue: sue, eval: ev, fl: fl, rpc: rpc});
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (state_update_en === 1'b1 || eval_branch === 1'b1 || flush === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'b0, state_update_en, eval_branch, flush}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulses{sue,eval,flush}", {29'b0, state_update_en, eval_branch, flush},
                          {29'b0, e.sue, e.eval, e.fl});
                    if (e.eval) check("redirect_pc", redirect_pc, e.rpc);
                end
            end
        end
    endtask

    function automatic logic ent_taken(input int k); return (k % 2) == 0; endfunction
    function automatic logic ent_cond(input int k);  return (k % 3) != 0; endfunction
    function automatic logic [31:0] ent_tgt(input int k); return 32'h1000 + 32'(k) * 16; endfunction
    function automatic logic [31:0] ent_pc4(input int k); return 32'h2000 + 32'(k) * 4; endfunction

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_full", {31'b0, full}, 0);
        check("rst_empty", {31'b0, empty}, 1);
        check("rst_pulses", {29'b0, state_update_en, eval_branch, flush}, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_errs", {30'b0, err_underflow, err_overflow}, 0);
        check("rst_cnts", {branch_cnt, mispredict_cnt}, 0);

        // Correct taken prediction
        drive(1, 1, 32'h100, 32'h24, 1, 0, 0, 0);
        check("ct_empty_after_push", {31'b0, empty}, 0);
        expect_pulse(1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h100);
        check("ct_branch_cnt", {16'b0, branch_cnt}, 1);
        check("ct_mispredict_cnt", {16'b0, mispredict_cnt}, 0);
        check("ct_empty", {31'b0, empty}, 1);

        // Direction mispredict with younger entries and a same-cycle push
        drive(1, 1, 32'h300, 32'h44, 1, 0, 0, 0);
        drive(1, 0, 32'h0,   32'h48, 1, 0, 0, 0);
        drive(1, 1, 32'h500, 32'h4c, 1, 0, 0, 0);
        expect_pulse(1, 1, 1, 32'h44);
        drive(1, 1, 32'h600, 32'h50, 1, 1, 0, 32'h0);
        check("dm_empty", {31'b0, empty}, 1);
        check("dm_no_overflow", {31'b0, err_overflow}, 0);
        check("dm_mispredict_cnt", {16'b0, mispredict_cnt}, 1);
        drive(1, 1, 32'h700, 32'h54, 1, 0, 0, 0);
        drive(1, 1, 32'h700, 32'h54, 1, 1, 1, 32'h700);
        drive(1, 1, 32'h700, 32'h54, 1, 0, 0, 0);
        check("drain_ignored_empty", {31'b0, empty}, 1);
        check("drain_no_errs", {30'b0, err_underflow, err_overflow}, 0);
        check("drain_branch_cnt", {16'b0, branch_cnt}, 2);
        drive(1, 0, 32'h0, 32'h60, 1, 0, 0, 0);
        check("normal_push_accepted", {31'b0, empty}, 0);
        expect_pulse(1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h1234);
        check("nt_correct_cnts", {branch_cnt, mispredict_cnt}, {16'd3, 16'd1});

        // JAL target mispredict
        drive(1, 1, 32'h200, 32'h08, 0, 0, 0, 0);
        expect_pulse(0, 1, 1, 32'h204);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h204);
        check("jal_cnts", {branch_cnt, mispredict_cnt}, {16'd4, 16'd2});
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Full, overflow, push+pop while full, ordered drain across wrap
        for (int k = 0; k < 4; k++) drive(1, ent_taken(k), ent_tgt(k), ent_pc4(k), ent_cond(k), 0, 0, 0);
        check("full_after_4", {30'b0, full, empty}, 32'h2);
        drive(1, ent_taken(4), ent_tgt(4), ent_pc4(4), ent_cond(4), 0, 0, 0);
        check("overflow_set", {31'b0, err_overflow}, 1);
        check("overflow_still_full", {31'b0, full}, 1);
        for (int k = 4; k < 10; k++) begin
            if (ent_cond(k - 4)) expect_pulse(1, 0, 0, 0);
            drive(1, ent_taken(k), ent_tgt(k), ent_pc4(k), ent_cond(k),
                  1, ent_taken(k - 4), ent_taken(k - 4) ? ent_tgt(k - 4) : 32'hdead);
            check($sformatf("pushpop_full_%0d", k), {31'b0, full}, 1);
        end
        for (int k = 6; k < 10; k++) begin
            if (ent_cond(k)) expect_pulse(1, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 1, ent_taken(k), ent_taken(k) ? ent_tgt(k) : 32'hbeef);
        end
        check("wrap_empty", {30'b0, full, empty}, 32'h1);
        check("wrap_cnts", {branch_cnt, mispredict_cnt}, {16'd14, 16'd2});

        // Underflow
        drive(0, 0, 0, 0, 0, 1, 1, 32'h0);
        check("underflow_set", {31'b0, err_underflow}, 1);
        check("underflow_branch_cnt", {16'b0, branch_cnt}, 14);

        // Reset during DRAIN
        drive(1, 1, 32'h800, 32'h80, 1, 0, 0, 0);
        expect_pulse(1, 1, 1, 32'h80);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_empty", {31'b0, empty}, 1);
        check("rst2_errs", {30'b0, err_underflow, err_overflow}, 0);
        check("rst2_cnts", {branch_cnt, mispredict_cnt}, 0);
        drive(1, 0, 32'h0, 32'h90, 1, 0, 0, 0);
        check("rst2_normal_push", {31'b0, empty}, 0);
        expect_pulse(1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        check("rst2_branch_cnt", {16'b0, branch_cnt}, 1);

        // Saturation on the CNT_W=4, DRAIN_CYCLES=0 instance
        for (int i = 1; i <= 20; i++) begin
            push_valid_s = 1'b1;
            step();
            push_valid_s = 1'b0;
            resolve_valid_s = 1'b1;
            resolve_taken_s = 1'b0;
            step();
            resolve_valid_s = 1'b0;
            step();
            if (i == 3) check("sat_mid_cnt", {28'b0, mispredict_cnt_s}, 3);
        end
        check("sat_mispredict_cnt", {28'b0, mispredict_cnt_s}, 15);
        check("sat_branch_cnt", {28'b0, branch_cnt_s}, 15);
        check("sat_no_underflow", {31'b0, eu_s}, 0);

        step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
